pipeline_ctrl: RTL

// - Central stall/flush sequencer for the IF/DEC/EXE/MEM pipeline.
// - Merges requests from the branch unit (hold, flush, redirect), load-use hazards and data-memory wait.
// - Drives per-stage register enables, bubble injects and the PC load. Replaces ad-hoc hold/flush fan-out.

---
 rtl/pipeline_ctrl_if.sv | 81 ++++++++
 rtl/pipeline_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
//
// Bundle between the pipeline datapath / branch unit and the central
// stall/flush sequencer (pipeline_ctrl).
//
//   Requests (datapath -> controller)
//     hold_req        branch unit asks for a DEC hold (JAL/JALR/predicted-taken)
//     flush_req       branch unit resolved a mispredict/JALR in EXE
//     flush_target    PC to load when flush_req is honoured
//     load_use        load-use hazard detected in DEC
//     mem_busy        data memory not ready this cycle
//
//   Controls (controller -> datapath)
//     pc_en           PC register enable
//     pc_load         load PC from pc_target instead of incrementing
//     pc_target       redirect PC (holds last loaded value)
//     if_dec_en       IF/DEC pipe-register enable
//     dec_exe_en      DEC/EXE pipe-register enable
//     exe_mem_en      EXE/MEM pipe-register enable
//     if_dec_bubble   write a NOP into IF/DEC on the next edge
//     dec_exe_bubble  write a NOP into DEC/EXE on the next edge
//     mem_fault       sticky data-memory timeout indication
//     ctrl_state      current sequencer state (debug)
//
// Modports: master = datapath/branch-unit side, slave = controller side.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;
    logic        hold_req;
    logic        flush_req;
    logic [31:0] flush_target;
    logic        load_use;
    logic        mem_busy;

    logic        pc_en;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        if_dec_en;
    logic        dec_exe_en;
    logic        exe_mem_en;
    logic        if_dec_bubble;
    logic        dec_exe_bubble;
    logic        mem_fault;
    logic [2:0]  ctrl_state;

    modport master (
        output hold_req,
        output flush_req,
        output flush_target,
        output load_use,
        output mem_busy,
        input  pc_en,
        input  pc_load,
        input  pc_target,
        input  if_dec_en,
        input  dec_exe_en,
        input  exe_mem_en,
        input  if_dec_bubble,
        input  dec_exe_bubble,
        input  mem_fault,
        input  ctrl_state
    );

    modport slave (
        input  hold_req,
        input  flush_req,
        input  flush_target,
        input  load_use,
        input  mem_busy,
        output pc_en,
        output pc_load,
        output pc_target,
        output if_dec_en,
        output dec_exe_en,
        output exe_mem_en,
        output if_dec_bubble,
        output dec_exe_bubble,
        output mem_fault,
        output ctrl_state
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush sequencer for the IF/DEC/EXE/MEM pipeline. Merges the
// branch-unit requests (hold, flush/redirect), load-use hazards and data
// memory wait into per-stage register enables, bubble injects and the PC load.
//
// Parameters
//   STALL_CYCLES  cycles DEC stays frozen per hold/load-use request (1..15)
//   MEM_TIMEOUT   consecutive MEM_WAIT busy cycles before a fault (1..255)
//   CNT_W         performance counter width (only with PIPE_PERF_CNT_EN)
//
// Ports
//   Clock         core clock, rising edge
//   nReset        asynchronous active-low reset
//   ctrl          pipeline_ctrl_if.slave: requests in, pipeline controls out
//   stall_cnt     cycles spent in STALL          (PIPE_PERF_CNT_EN only)
//   flush_cnt     flush events (PC redirects)    (PIPE_PERF_CNT_EN only)
//   memwait_cnt   cycles spent in MEM_WAIT       (PIPE_PERF_CNT_EN only)
//
// Optional feature macro: PIPE_PERF_CNT_EN adds the three wrapping counters.
//
// Request priority each cycle: mem_busy > flush_req > (hold_req | load_use).
// Flush and memory-wait effects are applied in the same cycle the request is
// seen; a hold/load-use request takes effect from the following cycle, when
// the STALL state drives the frozen-front-end controls.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic            Clock,
    input  logic            nReset,
    pipeline_ctrl_if.slave  ctrl
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    localparam logic [2:0] BOOT     = 3'd0;
    localparam logic [2:0] RUN      = 3'd1;
    localparam logic [2:0] STALL    = 3'd2;
    localparam logic [2:0] FLUSH    = 3'd3;
    localparam logic [2:0] MEM_WAIT = 3'd4;
    localparam logic [2:0] FAULT    = 3'd5;

    // STALL is left when the down-counter is already 0, so loading N-1 gives
    // exactly N cycles in STALL.
    localparam logic [3:0] STALL_LOAD  = 4'(STALL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    // Out-of-range configurations are rejected at elaboration.
    if (STALL_CYCLES < 1 || STALL_CYCLES > 15 ||
        MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : gBadParams
        $error("pipeline_ctrl: parameter out of range");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]  stateReg,      stateNext;
    logic [3:0]  stallCntReg,   stallCntNext;
    logic [7:0]  waitCntReg,    waitCntNext;
    logic        pendFlushReg,  pendFlushNext;
    logic [31:0] pendTargetReg, pendTargetNext;
    logic        pendStallReg,  pendStallNext;
    logic        faultReg,      faultNext;
    logic [31:0] pcTargetReg;

    // Combinational pipeline controls
    logic        pcEn;
    logic        pcLoad;
    logic [31:0] loadTarget;
    logic        ifDecEn;
    logic        decExeEn;
    logic        exeMemEn;
    logic        ifDecBubble;
    logic        decExeBubble;

    logic        holdAny;
    logic        flushNow;

    assign holdAny = ctrl.hold_req | ctrl.load_use;

    // A flush latched during the memory wait is replayed on the first
    // not-busy cycle of MEM_WAIT; a live flush_req in that cycle supersedes it.
    assign flushNow = ctrl.flush_req | ((stateReg == MEM_WAIT) & pendFlushReg);

    always_comb begin
        stateNext      = stateReg;
        stallCntNext   = stallCntReg;
        waitCntNext    = waitCntReg;
        pendFlushNext  = pendFlushReg;
        pendTargetNext = pendTargetReg;
        pendStallNext  = pendStallReg;
        faultNext      = faultReg;

        pcEn         = 1'b0;
        pcLoad       = 1'b0;
        loadTarget   = pcTargetReg;
        ifDecEn      = 1'b0;
        decExeEn     = 1'b0;
        exeMemEn     = 1'b0;
        ifDecBubble  = 1'b0;
        decExeBubble = 1'b0;

        case (stateReg)
            BOOT: begin
                // One quiet cycle after reset before the pipeline runs.
                stateNext = RUN;
            end

            RUN, STALL, FLUSH, MEM_WAIT: begin
                if (ctrl.mem_busy) begin
                    // Whole pipeline frozen, no bubbles. A redirect seen while
                    // frozen must not be lost: remember the newest one.
                    if (ctrl.flush_req) begin
                        pendFlushNext  = 1'b1;
                        pendTargetNext = ctrl.flush_target;
                    end
                    if (stateReg == MEM_WAIT) begin
                        waitCntNext = waitCntReg + 8'd1;
                        if (waitCntNext == TIMEOUT_VAL) begin
                            stateNext = FAULT;
                            faultNext = 1'b1;
                        end
                    end else begin
                        // Interrupted STALL is re-run in full afterwards,
                        // since DEC contents were not advanced meanwhile.
                        waitCntNext   = '0;
                        pendStallNext = (stateReg == STALL);
                        stateNext     = MEM_WAIT;
                    end
                end else begin
                    // Pending bookkeeping is consumed on MEM_WAIT exit.
                    if (stateReg == MEM_WAIT) begin
                        pendFlushNext = 1'b0;
                        pendStallNext = 1'b0;
                        waitCntNext   = '0;
                    end

                    if (flushNow) begin
                        // Redirect: squash IF/DEC and DEC/EXE, let the
                        // resolving instruction move on into MEM.
                        pcEn         = 1'b1;
                        pcLoad       = 1'b1;
                        loadTarget   = ctrl.flush_req ? ctrl.flush_target
                                                      : pendTargetReg;
                        ifDecEn      = 1'b1;
                        decExeEn     = 1'b1;
                        exeMemEn     = 1'b1;
                        ifDecBubble  = 1'b1;
                        decExeBubble = 1'b1;
                        stateNext    = FLUSH;
                    end else if (stateReg == STALL) begin
                        // Front end frozen, NOP fed into EXE. New requests
                        // arriving here do not extend the stall.
                        decExeEn     = 1'b1;
                        exeMemEn     = 1'b1;
                        decExeBubble = 1'b1;
                        if (stallCntReg == 4'd0) begin
                            stateNext = RUN;
                        end else begin
                            stallCntNext = stallCntReg - 4'd1;
                        end
                    end else begin
                        pcEn     = 1'b1;
                        ifDecEn  = 1'b1;
                        decExeEn = 1'b1;
                        exeMemEn = 1'b1;
                        // In FLUSH the DEC instruction is wrong-path, so its
                        // hazards are ignored.
                        if ((stateReg != FLUSH && holdAny) ||
                            (stateReg == MEM_WAIT && pendStallReg)) begin
                            stateNext    = STALL;
                            stallCntNext = STALL_LOAD;
                        end else begin
                            stateNext = RUN;
                        end
                    end
                end
            end

            FAULT: begin
                // Terminal until reset; all controls stay low.
                stateNext = FAULT;
            end

            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stateReg      <= BOOT;
            stallCntReg   <= '0;
            waitCntReg    <= '0;
            pendFlushReg  <= 1'b0;
            pendTargetReg <= '0;
            pendStallReg  <= 1'b0;
            faultReg      <= 1'b0;
            pcTargetReg   <= '0;
        end else begin
            stateReg      <= stateNext;
            stallCntReg   <= stallCntNext;
            waitCntReg    <= waitCntNext;
            pendFlushReg  <= pendFlushNext;
            pendTargetReg <= pendTargetNext;
            pendStallReg  <= pendStallNext;
            faultReg      <= faultNext;
            pcTargetReg   <= loadTarget;
        end
    end

    assign ctrl.pc_en          = pcEn;
    assign ctrl.pc_load        = pcLoad;
    assign ctrl.pc_target      = loadTarget;
    assign ctrl.if_dec_en      = ifDecEn;
    assign ctrl.dec_exe_en     = decExeEn;
    assign ctrl.exe_mem_en     = exeMemEn;
    assign ctrl.if_dec_bubble  = ifDecBubble;
    assign ctrl.dec_exe_bubble = decExeBubble;
    assign ctrl.mem_fault      = faultReg;
    assign ctrl.ctrl_state     = stateReg;

`ifdef PIPE_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^CNT_W)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stallCountReg;
    logic [CNT_W-1:0] flushCountReg;
    logic [CNT_W-1:0] memWaitCountReg;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stallCountReg   <= '0;
            flushCountReg   <= '0;
            memWaitCountReg <= '0;
        end else begin
            if (stateReg == STALL) begin
                stallCountReg <= stallCountReg + 1'b1;
            end
            if (pcLoad) begin
                flushCountReg <= flushCountReg + 1'b1;
            end
            if (stateReg == MEM_WAIT) begin
                memWaitCountReg <= memWaitCountReg + 1'b1;
            end
        end
    end

    assign stall_cnt   = stallCountReg;
    assign flush_cnt   = flushCountReg;
    assign memwait_cnt = memWaitCountReg;
`endif

endmodule
